// File: rtl/sum_latch_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module  : sum_latch_uart_tx_if
// Strobe/operand inputs and UART/status outputs of the sum-latch transmitter.
// Revision: 1.0
// ============================================================================
interface sum_latch_uart_tx_if #(
  parameter int DATA_W = 4
) ();
  logic              save_a_n;
  logic              save_b_n;
  logic [DATA_W-1:0] data_input;
  logic              uart_tx;
  logic              uart_tx_busy;
  logic [DATA_W:0]   sum_out;
  logic              drop_err;

  modport master (
    output save_a_n, save_b_n, data_input,
    input  uart_tx, uart_tx_busy, sum_out, drop_err
  );

  modport slave (
    input  save_a_n, save_b_n, data_input,
    output uart_tx, uart_tx_busy, sum_out, drop_err
  );
endinterface
`default_nettype wire

// File: rtl/sum_latch_uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : sum_latch_uart_tx
// Latches two strobed operands, adds them and sends the sum as 8N1 UART bytes.
// Revision: 1.0
// ============================================================================
module sum_latch_uart_tx #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 104,
  parameter int SYNC_STAGES  = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  sum_latch_uart_tx_if.slave bus
);

  localparam int c_NUM_BYTES = (DATA_W + 8) / 8;
  localparam int c_BYTE_W    = (c_NUM_BYTES > 1) ? $clog2(c_NUM_BYTES) : 1;
  localparam int c_WORD_W    = (1 << c_BYTE_W) * 8;
  localparam int c_BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [c_BYTE_W-1:0] c_LAST_BYTE = c_BYTE_W'(c_NUM_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [SYNC_STAGES:0]  r_sync_a;
  logic [SYNC_STAGES:0]  r_sync_b;
  logic [DATA_W-1:0]     r_op_a;
  logic [DATA_W-1:0]     r_op_b;
  logic [DATA_W-1:0]     r_acc_a;
  logic                  r_drop_err;
  logic [c_BAUD_W-1:0]   r_baud;
  logic [2:0]            r_bit_idx;
  logic [c_BYTE_W-1:0]   r_byte_idx;
  logic                  w_pa;
  logic                  w_pb;
  logic                  w_accept;
  logic                  w_baud_done;
  logic [DATA_W-1:0]     w_op_a_eff;
  logic [DATA_W:0]       w_sum;
  logic [c_WORD_W-1:0]   w_tx_word;
  logic                  w_tx;
  logic                  w_busy;

  // Top bit of each chain is the previous synchronised value, used for edge detect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync_a <= '1;
      r_sync_b <= '1;
    end else begin
      r_sync_a <= {r_sync_a[SYNC_STAGES-1:0], bus.save_a_n};
      r_sync_b <= {r_sync_b[SYNC_STAGES-1:0], bus.save_b_n};
    end
  end

  assign w_pa       = r_sync_a[SYNC_STAGES] & ~r_sync_a[SYNC_STAGES-1];
  assign w_pb       = r_sync_b[SYNC_STAGES] & ~r_sync_b[SYNC_STAGES-1];
  assign w_accept   = w_pb && (r_state == S_IDLE);
  assign w_op_a_eff = w_pa ? bus.data_input : r_op_a;

  // r_acc_a/r_op_b only change on acceptance, so together they are the frame snapshot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_acc_a    <= '0;
      r_drop_err <= 1'b0;
    end else begin
      if (w_pa)
        r_op_a <= bus.data_input;
      if (w_accept) begin
        r_acc_a    <= w_op_a_eff;
        r_op_b     <= bus.data_input;
        r_drop_err <= 1'b0;
      end else if (w_pb) begin
        r_drop_err <= 1'b1;
      end
    end
  end

  assign w_sum       = {1'b0, r_acc_a} + {1'b0, r_op_b};
  assign w_tx_word   = c_WORD_W'(w_sum);
  assign w_baud_done = (r_baud == c_BAUD_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == S_IDLE) || w_baud_done)
        r_baud <= '0;
      else
        r_baud <= r_baud + c_BAUD_W'(1);
      if (r_state == S_IDLE) begin
        r_bit_idx  <= '0;
        r_byte_idx <= '0;
      end else if (w_baud_done) begin
        if (r_state == S_DATA)
          r_bit_idx <= r_bit_idx + 3'd1;
        if ((r_state == S_STOP) && (r_byte_idx != c_LAST_BYTE))
          r_byte_idx <= r_byte_idx + c_BYTE_W'(1);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_tx         = 1'b1;
    w_busy       = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_accept)
          w_state_next = S_START;
      end
      S_START: begin
        w_tx = 1'b0;
        if (w_baud_done)
          w_state_next = S_DATA;
      end
      S_DATA: begin
        w_tx = w_tx_word[{r_byte_idx, r_bit_idx}];
        if (w_baud_done && (r_bit_idx == 3'd7))
          w_state_next = S_STOP;
      end
      S_STOP: begin
        // Further bytes follow the stop bit directly, with no idle gap.
        if (w_baud_done)
          w_state_next = (r_byte_idx == c_LAST_BYTE) ? S_IDLE : S_START;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign bus.uart_tx      = w_tx;
  assign bus.uart_tx_busy = w_busy;
  assign bus.sum_out      = w_sum;
  assign bus.drop_err     = r_drop_err;

endmodule
`default_nettype wire

// File: tb/tb_sum_latch_uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_sum_latch_uart_tx
// Self-checking bench for sum_latch_uart_tx (DATA_W=4 and DATA_W=12 instances).
// Revision: 1.0
// ============================================================================
module tb_sum_latch_uart_tx;

  localparam int c_CPB = 4;

  typedef struct {
    bit dsel;
    int a;
    int b;
    int exp_sum;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  bit   dsel;
  int   n_checks = 0;
  int   n_err    = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  sum_latch_uart_tx_if #(.DATA_W(4))  b4 ();
  sum_latch_uart_tx_if #(.DATA_W(12)) b12 ();

  sum_latch_uart_tx #(.DATA_W(4), .CLKS_PER_BIT(c_CPB), .SYNC_STAGES(2)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .bus(b4)
  );
  sum_latch_uart_tx #(.DATA_W(12), .CLKS_PER_BIT(c_CPB), .SYNC_STAGES(2)) u_dut12 (
    .clk(clk), .reset_n(reset_n), .bus(b12)
  );

  logic        mon_tx, mon_busy, mon_drop;
  logic [16:0] mon_sum;
  assign mon_tx   = dsel ? b12.uart_tx      : b4.uart_tx;
  assign mon_busy = dsel ? b12.uart_tx_busy : b4.uart_tx_busy;
  assign mon_drop = dsel ? b12.drop_err     : b4.drop_err;
  assign mon_sum  = dsel ? {4'b0, b12.sum_out} : {12'b0, b4.sum_out};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_data(input int d);
    b4.data_input  = 4'(d);
    b12.data_input = 12'(d);
  endtask

  task automatic set_strobes(input bit a_n, input bit b_n);
    if (dsel) begin
      b12.save_a_n = a_n;
      b12.save_b_n = b_n;
    end else begin
      b4.save_a_n = a_n;
      b4.save_b_n = b_n;
    end
  endtask

  task automatic pulse(input bit a_n, input bit b_n, input int d);
    set_data(d);
    set_strobes(a_n, b_n);
    tick(2);
    set_strobes(1'b1, 1'b1);
  endtask

  function automatic int num_bytes(input bit sel);
    return sel ? 2 : 1;
  endfunction

  // Expected line level t cycles after the first busy cycle: 10-bit 8N1 slots per byte.
  function automatic bit exp_line(input int sum, input int t);
    int slot, byte_n, pos;
    slot   = t / c_CPB;
    byte_n = slot / 10;
    pos    = slot % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return 1'((sum >> (8 * byte_n + pos - 1)) & 1);
  endfunction

  task automatic run_frame(input int exp_sum, input string tag);
    int waited   = 0;
    int busy_cnt = 0;
    int total;
    total = num_bytes(dsel) * 10 * c_CPB;
    while (!mon_busy && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, " busy_start"}, 32'(mon_busy), 1);
    if (!mon_busy) return;
    check({tag, " sum_out"}, 32'(mon_sum), 32'(exp_sum));
    for (int t = 0; t < total; t++) begin
      if (t > 0) @(negedge clk);
      busy_cnt += int'(mon_busy);
      if (t % c_CPB == c_CPB / 2)
        check($sformatf("%s slot%0d", tag, t / c_CPB), 32'(mon_tx), 32'(exp_line(exp_sum, t)));
    end
    @(negedge clk);
    check({tag, " busy_len"}, 32'(busy_cnt), 32'(total));
    check({tag, " busy_fall"}, 32'(mon_busy), 0);
    check({tag, " line_idle"}, 32'(mon_tx), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises, bad;
    bit prev;
    reset_n = 1'b0;
    dsel    = 1'b0;
    b4.save_a_n = 1'b1;  b4.save_b_n = 1'b1;  b4.data_input = '0;
    b12.save_a_n = 1'b1; b12.save_b_n = 1'b1; b12.data_input = '0;
    tick(3);
    reset_n = 1'b1;
    tick(2);

    for (int s = 0; s < 2; s++) begin
      dsel = 1'(s);
      #0;
      check($sformatf("reset%0d tx", s), 32'(mon_tx), 1);
      check($sformatf("reset%0d busy", s), 32'(mon_busy), 0);
      check($sformatf("reset%0d sum", s), 32'(mon_sum), 0);
      check($sformatf("reset%0d drop", s), 32'(mon_drop), 0);
    end

    vecs.push_back('{1'b0, 5, 7, 32'h0C});
    vecs.push_back('{1'b0, 15, 15, 32'h1E});
    vecs.push_back('{1'b1, 32'hFFF, 1, 32'h1000});
    for (int i = 0; i < 6; i++) begin
      vec_t v;
      v.dsel = 1'b0;
      v.a = int'($urandom_range(0, 15));
      v.b = int'($urandom_range(0, 15));
      v.exp_sum = v.a + v.b;
      vecs.push_back(v);
    end
    for (int i = 0; i < 4; i++) begin
      vec_t v;
      v.dsel = 1'b1;
      v.a = int'($urandom_range(0, 4095));
      v.b = int'($urandom_range(0, 4095));
      v.exp_sum = v.a + v.b;
      vecs.push_back(v);
    end

    foreach (vecs[i]) begin
      dsel = vecs[i].dsel;
      pulse(1'b0, 1'b1, vecs[i].a);
      tick(4);
      pulse(1'b1, 1'b0, vecs[i].b);
      run_frame(vecs[i].exp_sum, $sformatf("vec%0d", i));
    end

    // Mid-frame strobes: rejected save_b and a late save_a must not touch the frame.
    dsel = 1'b0;
    pulse(1'b0, 1'b1, 5);
    tick(4);
    pulse(1'b1, 1'b0, 7);
    fork
      run_frame(12, "mid");
      begin
        tick(8);
        pulse(1'b1, 1'b0, 3);
        tick(4);
        pulse(1'b0, 1'b1, 9);
      end
    join
    check("mid drop_set", 32'(mon_drop), 1);
    check("mid sum_kept", 32'(mon_sum), 12);
    pulse(1'b1, 1'b0, 1);
    run_frame(10, "after_mid");
    check("after_mid drop_clr", 32'(mon_drop), 0);

    // save_b held low for 200 cycles yields exactly one frame.
    pulse(1'b0, 1'b1, 2);
    tick(4);
    set_data(3);
    set_strobes(1'b1, 1'b0);
    rises = 0;
    prev  = mon_busy;
    for (int i = 0; i < 240; i++) begin
      @(negedge clk);
      if (i == 200) set_strobes(1'b1, 1'b1);
      if (mon_busy && !prev) rises++;
      prev = mon_busy;
    end
    check("hold frames", 32'(rises), 1);
    check("hold sum", 32'(mon_sum), 5);

    // Simultaneous strobes: sum is twice the bus value.
    pulse(1'b0, 1'b0, 6);
    run_frame(12, "both");

    // Asynchronous reset in the middle of a data bit.
    pulse(1'b0, 1'b1, 5);
    tick(4);
    pulse(1'b1, 1'b0, 7);
    bad = 0;
    while (!mon_busy && bad < 20) begin
      @(negedge clk);
      bad++;
    end
    check("rst busy_start", 32'(mon_busy), 1);
    tick(10);
    #1 reset_n = 1'b0;
    #1;
    check("rst tx_async", 32'(mon_tx), 1);
    check("rst busy_async", 32'(mon_busy), 0);
    check("rst sum_async", 32'(mon_sum), 0);
    tick(3);
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mon_tx !== 1'b1 || mon_busy !== 1'b0) bad++;
    end
    check("rst idle_after", 32'(bad), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
